// File: rtl/spi_wb_bridge.sv
// spi_wb_bridge: SPI (mode 0) slave to Wishbone B4 pipelined master, one transaction at a time.
// Define SPI_WB_AUTOINC_EN to turn extra write-frame bytes into writes at incrementing addresses.
module spi_wb_bridge #(
    parameter int WB_ADDR_WIDTH = 20,
    parameter int DATA_WIDTH    = 8
) (
    input  logic                     wb_clock_i,
    input  logic                     wb_reset_i,
    input  logic                     spi_cs_ni,
    input  logic                     spi_sck_i,
    input  logic                     spi_sdi_i,
    output logic                     spi_sdo_o,
    output logic                     spi_ready_o,
    output logic                     overrun_o,
    output logic [WB_ADDR_WIDTH-1:0] wb_addr_o,
    output logic [DATA_WIDTH-1:0]    wb_data_o,
    input  logic [DATA_WIDTH-1:0]    wb_data_i,
    output logic                     wb_we_o,
    output logic                     wb_cycle_o,
    output logic                     wb_strobe_o,
    input  logic                     wb_stall_i,
    input  logic                     wb_ack_i
);
    typedef enum logic [1:0] {IDLE, REQ, WAIT_ACK} state_t;

    state_t                   state_q, state_d;
    logic [1:0]               cs_sync_q, sck_sync_q, sdi_sync_q;
    logic                     cs_prev_q, sck_prev_q;
    logic [2:0]               bit_q, bit_d, byte_q, byte_d;
    logic [DATA_WIDTH-1:0]    shift_q, shift_d, miso_q, miso_d, rdata_q, rdata_d;
    logic [DATA_WIDTH-1:0]    wb_data_q, wb_data_d;
    logic [1:0]               cmd_q, cmd_d;
    logic [WB_ADDR_WIDTH-1:0] faddr_q, faddr_d, wb_addr_q, wb_addr_d, req_addr;
    logic                     done_q, done_d, wb_we_q, wb_we_d;
    logic                     overrun_q, overrun_d, ready_q, ready_d;
    logic                     cs_s, sck_s, sdi_s, cs_fall, cs_rise, sck_rise, sck_fall;
    logic                     fire, req_we, ack_ok;
    logic [DATA_WIDTH-1:0]    sh;

    assign cs_s     = cs_sync_q[1];
    assign sck_s    = sck_sync_q[1];
    assign sdi_s    = sdi_sync_q[1];
    assign cs_fall  = cs_prev_q & ~cs_s;
    assign cs_rise  = ~cs_prev_q & cs_s;
    assign sck_rise = ~sck_prev_q & sck_s & ~cs_s;
    assign sck_fall = sck_prev_q & ~sck_s & ~cs_s;
    assign sh       = {shift_q[DATA_WIDTH-2:0], sdi_s};

    always_comb begin
        bit_d     = bit_q;
        byte_d    = byte_q;
        shift_d   = shift_q;
        miso_d    = miso_q;
        cmd_d     = cmd_q;
        faddr_d   = faddr_q;
        done_d    = done_q;
        fire      = 1'b0;
        req_addr  = faddr_q;
        req_we    = cmd_q == 2'b10;
        if (cs_fall || cs_rise) begin
            bit_d  = 3'd0;
            byte_d = 3'd0;
            done_d = 1'b0;
        end
        if (cs_fall)
            miso_d = rdata_q;
        if (sck_fall)
            miso_d = {miso_q[DATA_WIDTH-2:0], 1'b0};
        if (sck_rise) begin
            bit_d   = bit_q + 3'd1;
            shift_d = sh;
            if (bit_q == 3'd7) begin
                byte_d = byte_q == 3'd4 ? 3'd4 : byte_q + 3'd1;
                if (byte_q == 3'd0) begin
                    cmd_d                        = sh[7:6];
                    faddr_d[WB_ADDR_WIDTH-1:16] = sh[3:0];
                end
                if (byte_q == 3'd1)
                    faddr_d[15:8] = sh;
                if (byte_q == 3'd2) begin
                    faddr_d[7:0] = sh;
                    req_addr     = {faddr_q[WB_ADDR_WIDTH-1:8], sh};
                    fire         = cmd_q == 2'b11;
                end
                if (byte_q == 3'd3)
                    fire = cmd_q == 2'b10;
`ifdef SPI_WB_AUTOINC_EN
                // each further byte of a write frame targets the next address, wrapping at the top
                if (byte_q == 3'd4 && cmd_q == 2'b10) begin
                    req_addr = faddr_q + WB_ADDR_WIDTH'(1);
                    faddr_d  = req_addr;
                    fire     = 1'b1;
                end
`endif
                done_d = done_q | fire;
            end
        end
    end

    assign ack_ok = wb_ack_i && (state_q == WAIT_ACK || (state_q == REQ && !wb_stall_i));

    always_comb begin
        state_d   = state_q;
        wb_addr_d = wb_addr_q;
        wb_data_d = wb_data_q;
        wb_we_d   = wb_we_q;
        overrun_d = overrun_q;
        rdata_d   = ack_ok && !wb_we_q ? wb_data_i : rdata_q;
        if (fire && state_q == IDLE) begin
            state_d   = REQ;
            wb_addr_d = req_addr;
            wb_we_d   = req_we;
            wb_data_d = req_we ? sh : wb_data_q;
        end else if (fire)
            overrun_d = 1'b1;
        if (state_q == REQ && !wb_stall_i)
            state_d = wb_ack_i ? IDLE : WAIT_ACK;
        if (state_q == WAIT_ACK && wb_ack_i)
            state_d = IDLE;
        ready_d = state_d == IDLE && (cs_s || done_d);
    end

    always_ff @(posedge wb_clock_i) begin
        if (wb_reset_i) begin
            state_q    <= IDLE;
            cs_sync_q  <= 2'b11;
            sck_sync_q <= 2'b00;
            sdi_sync_q <= 2'b00;
            cs_prev_q  <= 1'b1;
            sck_prev_q <= 1'b0;
            bit_q      <= 3'd0;
            byte_q     <= 3'd0;
            shift_q    <= '0;
            miso_q     <= '0;
            rdata_q    <= '0;
            cmd_q      <= 2'b00;
            faddr_q    <= '0;
            done_q     <= 1'b0;
            wb_addr_q  <= '0;
            wb_data_q  <= '0;
            wb_we_q    <= 1'b0;
            overrun_q  <= 1'b0;
            ready_q    <= 1'b1;
        end else begin
            state_q    <= state_d;
            cs_sync_q  <= {cs_sync_q[0], spi_cs_ni};
            sck_sync_q <= {sck_sync_q[0], spi_sck_i};
            sdi_sync_q <= {sdi_sync_q[0], spi_sdi_i};
            cs_prev_q  <= cs_s;
            sck_prev_q <= sck_s;
            bit_q      <= bit_d;
            byte_q     <= byte_d;
            shift_q    <= shift_d;
            miso_q     <= miso_d;
            rdata_q    <= rdata_d;
            cmd_q      <= cmd_d;
            faddr_q    <= faddr_d;
            done_q     <= done_d;
            wb_addr_q  <= wb_addr_d;
            wb_data_q  <= wb_data_d;
            wb_we_q    <= wb_we_d;
            overrun_q  <= overrun_d;
            ready_q    <= ready_d;
        end
    end

    assign spi_sdo_o   = miso_q[DATA_WIDTH-1];
    assign spi_ready_o = ready_q;
    assign overrun_o   = overrun_q;
    assign wb_addr_o   = wb_addr_q;
    assign wb_data_o   = wb_data_q;
    assign wb_we_o     = wb_we_q;
    assign wb_cycle_o  = state_q != IDLE;
    assign wb_strobe_o = state_q == REQ;
endmodule

// File: tb/tb_spi_wb_bridge.sv
// tb_spi_wb_bridge: directed bench driving SPI frames into spi_wb_bridge against a stall/ack slave model.
module tb_spi_wb_bridge;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cs_n = 1'b1, sck = 1'b0, sdi = 1'b0;
    logic        sdo, ready, overrun, we, cyc, stb, ack;
    logic [19:0] addr;
    logic [7:0]  wdata;
    logic [7:0]  rd_value = 8'h00;
    logic        stall;
    int          stall_len = 0;
    int          stall_ctr = 0;
    int          acc_cnt = 0;
    int          stb_cycles = 0;
    int          vectors = 0;
    int          misses = 0;
    logic [19:0] log_addr [16];
    logic [7:0]  log_data [16];
    logic        log_we   [16];

    always #5 clk = ~clk;

    spi_wb_bridge dut (
        .wb_clock_i (clk),
        .wb_reset_i (rst),
        .spi_cs_ni  (cs_n),
        .spi_sck_i  (sck),
        .spi_sdi_i  (sdi),
        .spi_sdo_o  (sdo),
        .spi_ready_o(ready),
        .overrun_o  (overrun),
        .wb_addr_o  (addr),
        .wb_data_o  (wdata),
        .wb_data_i  (rd_value),
        .wb_we_o    (we),
        .wb_cycle_o (cyc),
        .wb_strobe_o(stb),
        .wb_stall_i (stall),
        .wb_ack_i   (ack)
    );

    // slave: stalls the first stall_len strobe cycles, acks the cycle after acceptance
    assign stall = stb && (stall_ctr < stall_len);

    always @(posedge clk) begin
        if (rst) begin
            ack       <= 1'b0;
            stall_ctr <= 0;
        end else begin
            ack <= stb && !stall;
            if (stb)
                stb_cycles <= stb_cycles + 1;
            if (stb && stall)
                stall_ctr <= stall_ctr + 1;
            if (stb && !stall) begin
                stall_ctr          <= 0;
                log_addr[acc_cnt % 16] <= addr;
                log_data[acc_cnt % 16] <= wdata;
                log_we[acc_cnt % 16]   <= we;
                acc_cnt            <= acc_cnt + 1;
            end
        end
    end

    task automatic spi_byte(input logic [7:0] tx, output logic [7:0] rx);
        for (int i = 7; i >= 0; i--) begin
            sdi = tx[i];
            repeat (8) @(negedge clk);
            sck   = 1'b1;
            rx[i] = sdo;
            repeat (8) @(negedge clk);
            sck = 1'b0;
        end
    endtask

    task automatic spi_frame(input logic [39:0] tx, input int n, output logic [39:0] rx);
        logic [7:0] r;
        rx   = '0;
        cs_n = 1'b0;
        repeat (8) @(negedge clk);
        for (int k = 0; k < n; k++) begin
            spi_byte(tx[39-8*k -: 8], r);
            rx[39-8*k -: 8] = r;
        end
        repeat (8) @(negedge clk);
        cs_n = 1'b1;
        repeat (8) @(negedge clk);
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while (!(ready && !cyc) && n < 300) begin
            @(negedge clk);
            n++;
        end
        vectors++;
        if (!(ready && !cyc)) begin
            misses++;
            $display("FAIL %s: idle timeout ready=%0b cyc=%0b, required ready=1 cyc=0", name, ready, cyc);
        end
    endtask

    task automatic test_reset;
        repeat (4) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        vectors++;
        if ({ready, overrun, cyc, stb, we, sdo} !== 6'b100000) begin
            misses++;
            $display("FAIL reset_flags: got rdy/ovr/cyc/stb/we/sdo=%b, required 100000", {ready, overrun, cyc, stb, we, sdo});
        end
        vectors++;
        if ({addr, wdata} !== 28'h0) begin
            misses++;
            $display("FAIL reset_bus: got addr=%h data=%h, required 00000/00", addr, wdata);
        end
    endtask

    task automatic test_write;
        logic [39:0] rx;
        int a0 = acc_cnt, s0 = stb_cycles;
        stall_len = 0;
        spi_frame({8'h81, 8'h23, 8'h45, 8'hA5, 8'h00}, 4, rx);
        wait_idle("write_idle");
        vectors++;
        if (acc_cnt - a0 != 1 || stb_cycles - s0 != 1) begin
            misses++;
            $display("FAIL write_count: got %0d accepts %0d stb cycles, required 1/1", acc_cnt - a0, stb_cycles - s0);
        end
        vectors++;
        if ({log_addr[a0 % 16], log_data[a0 % 16], log_we[a0 % 16]} !== {20'h12345, 8'hA5, 1'b1}) begin
            misses++;
            $display("FAIL write_txn: got addr=%h data=%h we=%b, required 12345/a5/1", log_addr[a0 % 16], log_data[a0 % 16], log_we[a0 % 16]);
        end
    endtask

    task automatic test_read;
        logic [39:0] rx;
        int a0 = acc_cnt, s0 = stb_cycles;
        stall_len = 40;
        rd_value  = 8'h5A;
        spi_frame({8'hC0, 8'h80, 8'h00, 16'h0}, 3, rx);
        wait_idle("read_idle");
        vectors++;
        if (stb_cycles - s0 != 41 || acc_cnt - a0 != 1) begin
            misses++;
            $display("FAIL read_stall: got %0d stb cycles %0d accepts, required 41/1", stb_cycles - s0, acc_cnt - a0);
        end
        vectors++;
        if ({log_addr[a0 % 16], log_we[a0 % 16]} !== {20'h08000, 1'b0}) begin
            misses++;
            $display("FAIL read_txn: got addr=%h we=%b, required 08000/0", log_addr[a0 % 16], log_we[a0 % 16]);
        end
        rd_value  = 8'h00;
        stall_len = 0;
        spi_frame({8'h00, 8'h00, 24'h0}, 2, rx);
        vectors++;
        if (rx[39:24] !== 16'h5A00) begin
            misses++;
            $display("FAIL read_miso: got %h, required 5a00", rx[39:24]);
        end
        vectors++;
        if (acc_cnt != a0 + 1) begin
            misses++;
            $display("FAIL nop_traffic: got %0d accepts, required %0d", acc_cnt - a0, 1);
        end
    endtask

    task automatic test_framing;
        logic [39:0] rx;
        int a0 = acc_cnt;
        spi_frame({8'h81, 8'h23, 24'h0}, 2, rx);
        repeat (20) @(negedge clk);
        vectors++;
        if (acc_cnt != a0 || overrun !== 1'b0 || ready !== 1'b1) begin
            misses++;
            $display("FAIL framing_abort: got %0d accepts overrun=%b ready=%b, required 0/0/1", acc_cnt - a0, overrun, ready);
        end
        spi_frame({8'h80, 8'h00, 8'h10, 8'h3C, 8'h00}, 4, rx);
        wait_idle("framing_idle");
        vectors++;
        if (acc_cnt - a0 != 1 || {log_addr[a0 % 16], log_data[a0 % 16]} !== {20'h00010, 8'h3C}) begin
            misses++;
            $display("FAIL framing_next: got %0d accepts addr=%h data=%h, required 1/00010/3c", acc_cnt - a0, log_addr[a0 % 16], log_data[a0 % 16]);
        end
    endtask

    task automatic test_overrun;
        logic [39:0] rx;
        int a0 = acc_cnt;
        stall_len = 5000;
        spi_frame({8'h80, 8'h01, 8'h00, 8'h11, 8'h00}, 4, rx);
        vectors++;
        if ({stb, ready, overrun} !== 3'b100) begin
            misses++;
            $display("FAIL overrun_busy: got stb/ready/overrun=%b, required 100", {stb, ready, overrun});
        end
        spi_frame({8'h80, 8'h02, 8'h00, 8'h22, 8'h00}, 4, rx);
        vectors++;
        if (overrun !== 1'b1 || addr !== 20'h00100 || wdata !== 8'h11) begin
            misses++;
            $display("FAIL overrun_set: got overrun=%b addr=%h data=%h, required 1/00100/11", overrun, addr, wdata);
        end
        stall_len = 0;
        wait_idle("overrun_idle");
        repeat (10) @(negedge clk);
        vectors++;
        if (acc_cnt - a0 != 1 || log_data[a0 % 16] !== 8'h11 || overrun !== 1'b1) begin
            misses++;
            $display("FAIL overrun_single: got %0d accepts data=%h overrun=%b, required 1/11/1", acc_cnt - a0, log_data[a0 % 16], overrun);
        end
    endtask

    task automatic test_reset_in_req;
        logic [39:0] rx;
        int a0 = acc_cnt;
        stall_len = 5000;
        spi_frame({8'h80, 8'h03, 8'h00, 8'h33, 8'h00}, 4, rx);
        vectors++;
        if (stb !== 1'b1) begin
            misses++;
            $display("FAIL rst_req_pre: got stb=%b, required 1", stb);
        end
        rst = 1'b1;
        @(negedge clk);
        vectors++;
        if ({cyc, stb, ready, overrun} !== 4'b0010) begin
            misses++;
            $display("FAIL rst_req: got cyc/stb/ready/overrun=%b, required 0010", {cyc, stb, ready, overrun});
        end
        rst       = 1'b0;
        stall_len = 0;
        repeat (4) @(negedge clk);
        spi_frame({8'h00, 32'h0}, 1, rx);
        vectors++;
        if (rx[39:32] !== 8'h00 || acc_cnt != a0) begin
            misses++;
            $display("FAIL rst_rdata: got miso=%h accepts=%0d, required 00/0", rx[39:32], acc_cnt - a0);
        end
    endtask

    task automatic test_extra_bytes;
        logic [39:0] rx;
        int a0 = acc_cnt;
        int want;
        stall_len = 0;
        spi_frame({8'h8F, 8'hFF, 8'hFF, 8'h11, 8'h22}, 5, rx);
        wait_idle("extra_idle");
`ifdef SPI_WB_AUTOINC_EN
        want = 2;
`else
        want = 1;
`endif
        vectors++;
        if (acc_cnt - a0 != want || {log_addr[a0 % 16], log_data[a0 % 16]} !== {20'hFFFFF, 8'h11}) begin
            misses++;
            $display("FAIL extra_first: got %0d accepts addr=%h data=%h, required %0d/fffff/11", acc_cnt - a0, log_addr[a0 % 16], log_data[a0 % 16], want);
        end
`ifdef SPI_WB_AUTOINC_EN
        vectors++;
        if ({log_addr[(a0 + 1) % 16], log_data[(a0 + 1) % 16], log_we[(a0 + 1) % 16]} !== {20'h00000, 8'h22, 1'b1}) begin
            misses++;
            $display("FAIL autoinc_wrap: got addr=%h data=%h we=%b, required 00000/22/1", log_addr[(a0 + 1) % 16], log_data[(a0 + 1) % 16], log_we[(a0 + 1) % 16]);
        end
`endif
    endtask

    initial begin
        test_reset;
        test_write;
        test_read;
        test_framing;
        test_overrun;
        test_reset_in_req;
        test_extra_bytes;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, misses);
        $finish;
    end
endmodule
